debouncer: RTL and testbench
============================

DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The block SHALL expose parameter SYNC_STAGES, default 2, setting the number of synchronizer flops on btn_i (legal range >= 2).
REQ-002 The block SHALL expose parameter DEBOUNCE_CYCLES, default 1000000, setting the consecutive stable cycles required to accept a new level (legal range >= 1).
REQ-003 The block SHALL size its internal counter as CNT_W = $clog2(DEBOUNCE_CYCLES+1) bits, derived internally and not user-settable.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port btn_i, input, 1 bit: raw switch or button level, asynchronous to clk_i and possibly bouncing.
REQ-007 The block SHALL have port level_o, output, 1 bit, registered: the debounced level, intended to drive the en_i input of the downstream edge-pulse generator.
REQ-008 The block SHALL have port settling_o, output, 1 bit: high while a candidate level change is being qualified; decoded from the state register only, with no other combinational path from btn_i.

Function
REQ-009 The block SHALL pass btn_i through a SYNC_STAGES-deep flop chain; btn_s, the last stage, SHALL be the only form of btn_i the FSM sees.
REQ-010 The FSM SHALL have four states: LOW, RISE_WAIT, HIGH and FALL_WAIT.
REQ-011 In LOW with btn_s=1, the FSM SHALL move to RISE_WAIT and set cnt=0; otherwise it SHALL stay in LOW.
REQ-012 In RISE_WAIT with btn_s=0 (bounce), the FSM SHALL return to LOW, clear cnt and leave level_o unchanged.
REQ-013 In RISE_WAIT with btn_s=1 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL move to HIGH and set level_o=1 on the same edge.
REQ-014 In RISE_WAIT with btn_s=1 and cnt<DEBOUNCE_CYCLES-1, the FSM SHALL increment cnt by 1.
REQ-015 HIGH and FALL_WAIT SHALL mirror REQ-011 to REQ-014 with btn_s inverted and level_o cleared to 0 on the FALL_WAIT to HIGH-exit transition into LOW.
REQ-016 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 With DEBOUNCE_CYCLES=1, the FSM SHALL spend exactly one cycle in a WAIT state.
REQ-018 Latency: if btn_i is stable at a new value first sampled at edge 1, level_o SHALL change after edge SYNC_STAGES+DEBOUNCE_CYCLES+1; latency is identical for rise and fall.
REQ-019 Any btn_s excursion shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on level_o.
REQ-020 settling_o SHALL be 1 exactly in RISE_WAIT and FALL_WAIT.
REQ-021 level_o SHALL toggle at most once per DEBOUNCE_CYCLES+1 cycles, so the downstream pulse generator emits at most one pulse per accepted press.

Reset
REQ-022 While rst_i=1 at a clock edge, all sync flops, cnt and level_o SHALL be 0 and the state SHALL be LOW, with settling_o=0 after that edge.
REQ-023 Reset mid-qualification or while in HIGH SHALL force level_o=0 after the same edge, discarding partial counts.
REQ-024 After reset releases with btn_i=1, the block SHALL run the full REQ-018 latency before level_o rises.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-025 Hold rst_i=1 and btn_i=1 for 10 cycles -> level_o=0 and settling_o=0 throughout.
REQ-026 btn_i 0->1 first sampled at edge 1 and held -> settling_o=1 after edges 3 to 6; level_o=1 and settling_o=0 after edge 7.
REQ-027 btn_i high for 2 cycles, low for 1, then held high -> no level_o change during the bounce; level_o rises 7 edges after the final rise is first sampled.
REQ-028 From level_o=1, a btn_i low glitch of 3 cycles -> level_o stays 1; settling_o returns to 0 one edge after btn_s recovers.
REQ-029 From level_o=1, btn_i falls and is held low -> level_o=0 after the 7th edge; a downstream pulse generator emits exactly one pulse for a full press/release cycle.
REQ-030 rst_i asserted for 1 cycle while in RISE_WAIT (cnt=2) with btn_i held high -> level_o=0 and state LOW after that edge; level_o rises 7 edges after reset deassertion.

Source files
------------

// File: rtl/debouncer.sv
// Debouncer: synchronizes a raw button level and accepts a new level only
// after it has been stable for DEBOUNCE_CYCLES consecutive clock cycles.
module debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic settling_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   btn_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;

  assign btn_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain bringing btn_i into the clk_i domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn_i};
    end
  end

  // State, qualification counter and debounced level registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= LOW;
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
    end
  end

  // Next-state logic; a candidate level must survive DEBOUNCE_CYCLES more edges.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    case (state_r)
      LOW: begin
        cnt_nxt_s = '0;
        if (btn_s) begin
          state_nxt_s = RISE_WAIT;
        end else begin
          state_nxt_s = LOW;
        end
      end
      RISE_WAIT: begin
        if (!btn_s) begin
          state_nxt_s = LOW;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = HIGH;
          cnt_nxt_s   = '0;
          level_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      HIGH: begin
        cnt_nxt_s = '0;
        if (!btn_s) begin
          state_nxt_s = FALL_WAIT;
        end else begin
          state_nxt_s = HIGH;
        end
      end
      FALL_WAIT: begin
        if (btn_s) begin
          state_nxt_s = HIGH;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = LOW;
          cnt_nxt_s   = '0;
          level_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = LOW;
        cnt_nxt_s   = '0;
        level_nxt_s = 1'b0;
      end
    endcase
  end

  assign level_o    = level_r;
  assign settling_o = (state_r == RISE_WAIT) || (state_r == FALL_WAIT);

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer: directed scenarios plus randomized bouncing
// input, checked against a run-length reference model for two parameter sets.
module tb_debouncer;

  localparam int S0 = 2;
  localparam int D0 = 4;
  localparam int S1 = 3;
  localparam int D1 = 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic btn_i = 1'b0;
  logic level0, settling0, level1, settling1;

  int checks = 0;
  int errors = 0;

  debouncer #(.SYNC_STAGES(S0), .DEBOUNCE_CYCLES(D0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i),
    .level_o(level0), .settling_o(settling0)
  );

  debouncer #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i),
    .level_o(level1), .settling_o(settling1)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: btn_i history, and the run of consecutive edges on which
  // the synchronized input disagreed with the accepted level.
  int         m_s[2]   = '{S0, S1};
  int         m_d[2]   = '{D0, D1};
  logic [7:0] m_hist[2];
  int         m_run[2];
  logic       m_lvl[2];

  int cyc       = 0;
  int last_tog  = 0;
  logic prev_l0 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int idx, input logic r, input logic b);
    logic s;
    if (r) begin
      m_hist[idx] = 8'd0;
      m_run[idx]  = 0;
      m_lvl[idx]  = 1'b0;
    end else begin
      s = m_hist[idx][m_s[idx]-1];
      m_hist[idx] = {m_hist[idx][6:0], b};
      if (s != m_lvl[idx]) begin
        m_run[idx]++;
        if (m_run[idx] == m_d[idx] + 1) begin
          m_lvl[idx] = ~m_lvl[idx];
          m_run[idx] = 0;
        end
      end else begin
        m_run[idx] = 0;
      end
    end
  endtask

  // One clock edge with the given inputs, then compare both DUTs to the model.
  task automatic step(input logic r, input logic b);
    rst_i = r;
    btn_i = b;
    @(posedge clk_i);
    cyc++;
    model_step(0, r, b);
    model_step(1, r, b);
    #1;
    check_eq("lvl0", {31'd0, level0}, {31'd0, m_lvl[0]});
    check_eq("set0", {31'd0, settling0}, (m_run[0] > 0) ? 32'd1 : 32'd0);
    check_eq("lvl1", {31'd0, level1}, {31'd0, m_lvl[1]});
    check_eq("set1", {31'd0, settling1}, (m_run[1] > 0) ? 32'd1 : 32'd0);
    if (r) begin
      last_tog = cyc;
    end else if (level0 != prev_l0) begin
      check_eq("toggle_gap", ((cyc - last_tog) >= D0 + 1) ? 32'd1 : 32'd0, 32'd1);
      last_tog = cyc;
    end
    prev_l0 = level0;
  endtask

  initial begin
    int seg_len;
    logic seg_val;

    // Reset held with button pressed: outputs stay low throughout.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      check_eq("r025_lvl", {31'd0, level0}, 32'd0);
      check_eq("r025_set", {31'd0, settling0}, 32'd0);
    end

    // Clean rise after reset with button low.
    step(1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b1);
      check_eq("r026_set", {31'd0, settling0}, (e >= 3 && e <= 6) ? 32'd1 : 32'd0);
      check_eq("r026_lvl", {31'd0, level0}, (e >= 7) ? 32'd1 : 32'd0);
    end

    // Bounce on the rise: 1,1,0 then held; final rise first sampled at edge 4.
    step(1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, (e == 3) ? 1'b0 : 1'b1);
      check_eq("r027_lvl", {31'd0, level0}, (e >= 10) ? 32'd1 : 32'd0);
    end

    // Low glitch of 3 cycles from level 1 is rejected.
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, (e <= 3) ? 1'b0 : 1'b1);
      check_eq("r028_lvl", {31'd0, level0}, 32'd1);
      check_eq("r028_set", {31'd0, settling0}, (e >= 3 && e <= 5) ? 32'd1 : 32'd0);
    end

    // Sustained release.
    for (int e = 1; e <= 9; e++) begin
      step(1'b0, 1'b0);
      check_eq("r029_lvl", {31'd0, level0}, (e >= 7) ? 32'd0 : 32'd1);
    end

    // Reset in RISE_WAIT with cnt=2, then full latency after release.
    for (int e = 1; e <= 5; e++) begin
      step(1'b0, 1'b1);
    end
    check_eq("r030_mid_set", {31'd0, settling0}, 32'd1);
    step(1'b1, 1'b1);
    check_eq("r030_rst_lvl", {31'd0, level0}, 32'd0);
    check_eq("r030_rst_set", {31'd0, settling0}, 32'd0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b1);
      check_eq("r030_lvl", {31'd0, level0}, (e >= 7) ? 32'd1 : 32'd0);
    end

    // Reset while HIGH clears the level on the same edge.
    step(1'b1, 1'b1);
    check_eq("r023_lvl", {31'd0, level0}, 32'd0);

    // Randomized bouncing segments with rare resets.
    for (int k = 0; k < 400; k++) begin
      seg_val = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        seg_len = $urandom_range(6, 14);
      end else begin
        seg_len = $urandom_range(1, 5);
      end
      for (int i = 0; i < seg_len; i++) begin
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, seg_val);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
